// File: rtl/axi_ic_pkg.sv
// -----------------------------------------------------------------------------
// axi_ic_pkg
//   Shared definitions for the AXI write interconnect slice:
//     - write-path state encoding (IDLE/ADDR/DATA/RESP)
//     - master index constants for the 4-master grant vector
//     - BRESP response codes
//     - grant decode helpers (one-hot test, one-hot to index)
// -----------------------------------------------------------------------------
package axi_ic_pkg;

    // Write-path state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ADDR = ST_ADDR,
        DATA = ST_DATA,
        RESP = ST_RESP
    } wr_state_e;

    // Master indices within the grant vector
    localparam logic [1:0] AXI_MASTER_0 = 2'd0;
    localparam logic [1:0] AXI_MASTER_1 = 2'd1;
    localparam logic [1:0] AXI_MASTER_2 = 2'd2;
    localparam logic [1:0] AXI_MASTER_3 = 2'd3;

    // BRESP codes
    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;

    // True when exactly one grant bit is set
    function automatic logic grant_onehot(input logic [3:0] g);
        return (g != 4'b0000) && ((g & (g - 4'd1)) == 4'b0000);
    endfunction

    // Index of the set bit; only meaningful when grant_onehot(g)
    function automatic logic [1:0] grant_index(input logic [3:0] g);
        logic [1:0] idx;
        case (g)
            4'b0010: idx = AXI_MASTER_1;
            4'b0100: idx = AXI_MASTER_2;
            4'b1000: idx = AXI_MASTER_3;
            default: idx = AXI_MASTER_0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/axi_wr_beat_cnt.sv
// -----------------------------------------------------------------------------
// axi_wr_beat_cnt
//   Remaining-beat counter for one locked write burst, plus the sticky check
//   of the master's own WLAST against the counted position.
//
// Ports:
//   ACLK, ARESETn  clock, asynchronous active-low reset
//   load           AW handshake: count <= len
//   len            AWLEN of the locked master (beats - 1)
//   beat           W handshake on the slave side
//   mst_wlast      WLAST driven by the locked master
//   last           count == 0 (current beat is the final one)
//   wlast_err      sticky: some beat had mst_wlast != last
// -----------------------------------------------------------------------------
module axi_wr_beat_cnt (
    input  logic       ACLK,
    input  logic       ARESETn,
    input  logic       load,
    input  logic [7:0] len,
    input  logic       beat,
    input  logic       mst_wlast,
    output logic       last,
    output logic       wlast_err
);
    import axi_ic_pkg::*;

    logic [7:0] count;

    assign last = (count == 8'd0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            count     <= 8'd0;
            wlast_err <= 1'b0;
        end else begin
            if (load) begin
                count <= len;
            end else if (beat && !last) begin
                // Held at zero after the final beat: AWLEN=255 never wraps
                count <= count - 8'd1;
            end

            if (beat && (mst_wlast != last)) begin
                wlast_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_wr_router.sv
// -----------------------------------------------------------------------------
// axi_wr_router
//   Locks the master granted by the upstream 4-master write arbiter for one
//   full AXI4 write transaction (AW, W burst, B) and routes its channels to
//   the single slave port. Slave WLAST is generated from an AWLEN beat count.
//   The lock is released on the B handshake so the arbiter may rotate.
//
// Ports:
//   ACLK, ARESETn                      clock, asynchronous active-low reset
//   wgrnt[3:0]                         one-hot grant, bit i = master i
//   s_aw{valid,ready,addr,id,len}      per-master AW, fields packed by index
//   s_w{valid,ready,data,strb,last}    per-master W, fields packed by index
//   s_bvalid, s_bready                 per-master B handshake
//   s_bresp, s_bid                     B payload, broadcast to all masters
//   m_aw*, m_w*, m_b*                  slave-side channels
//   busy                               a transaction is locked (state != IDLE)
//   sel                                index of the locked master
//   wlast_err                          sticky master-WLAST vs count mismatch
// -----------------------------------------------------------------------------
module axi_wr_router #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [3:0]              wgrnt,

    input  logic [3:0]              s_awvalid,
    output logic [3:0]              s_awready,
    input  logic [4*ADDR_W-1:0]     s_awaddr,
    input  logic [4*ID_W-1:0]       s_awid,
    input  logic [4*8-1:0]          s_awlen,

    input  logic [3:0]              s_wvalid,
    output logic [3:0]              s_wready,
    input  logic [4*DATA_W-1:0]     s_wdata,
    input  logic [4*DATA_W/8-1:0]   s_wstrb,
    input  logic [3:0]              s_wlast,

    output logic [3:0]              s_bvalid,
    input  logic [3:0]              s_bready,
    output logic [1:0]              s_bresp,
    output logic [ID_W-1:0]         s_bid,

    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [ADDR_W-1:0]       m_awaddr,
    output logic [ID_W-1:0]         m_awid,
    output logic [7:0]              m_awlen,

    output logic                    m_wvalid,
    input  logic                    m_wready,
    output logic [DATA_W-1:0]       m_wdata,
    output logic [DATA_W/8-1:0]     m_wstrb,
    output logic                    m_wlast,

    input  logic                    m_bvalid,
    output logic                    m_bready,
    input  logic [1:0]              m_bresp,
    input  logic [ID_W-1:0]         m_bid,

    output logic                    busy,
    output logic [1:0]              sel,
    output logic                    wlast_err
);
    import axi_ic_pkg::*;

    localparam int STRB_W = DATA_W / 8;

    wr_state_e  state, state_nxt;
    logic [1:0] sel_nxt;
    logic       cnt_load;
    logic       cnt_beat;
    logic       cnt_last;

    // State and lock index
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= IDLE;
            sel   <= AXI_MASTER_0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
        end
    end

    // Next state and all handshake signals. Handshakes exist only in the
    // phase that owns them, so AW is never accepted in IDLE (one cycle of
    // lock latency) and W is never accepted before the AW handshake.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_nxt = state;
        sel_nxt   = sel;
        s_awready = 4'b0000;
        s_wready  = 4'b0000;
        s_bvalid  = 4'b0000;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_wlast   = 1'b0;
        m_bready  = 1'b0;
        cnt_load  = 1'b0;
        cnt_beat  = 1'b0;

        case (state)
            IDLE: begin
                if (grant_onehot(wgrnt) && ((wgrnt & s_awvalid) != 4'b0000)) begin
                    sel_nxt   = grant_index(wgrnt);
                    state_nxt = ADDR;
                end
            end

            ADDR: begin
                m_awvalid      = s_awvalid[sel];
                s_awready[sel] = m_awready;
                if (s_awvalid[sel] && m_awready) begin
                    cnt_load  = 1'b1;
                    state_nxt = DATA;
                end
            end

            DATA: begin
                m_wvalid      = s_wvalid[sel];
                s_wready[sel] = m_wready;
                m_wlast       = cnt_last;
                if (s_wvalid[sel] && m_wready) begin
                    cnt_beat = 1'b1;
                    if (cnt_last) begin
                        state_nxt = RESP;
                    end
                end
            end

            RESP: begin
                s_bvalid[sel] = m_bvalid;
                m_bready      = s_bready[sel];
                if (m_bvalid && s_bready[sel]) begin
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: payload muxes carry no reset; they are only observed alongside a
    // valid that is itself forced low through the reset of state.
    assign m_awaddr = s_awaddr[sel*ADDR_W +: ADDR_W];
    assign m_awid   = s_awid[sel*ID_W +: ID_W];
    assign m_awlen  = s_awlen[sel*8 +: 8];
    assign m_wdata  = s_wdata[sel*DATA_W +: DATA_W];
    assign m_wstrb  = s_wstrb[sel*STRB_W +: STRB_W];
    assign s_bresp  = m_bresp;
    assign s_bid    = m_bid;
    assign busy     = (state != IDLE);

    axi_wr_beat_cnt u_beat_cnt (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .load      (cnt_load),
        .len       (m_awlen),
        .beat      (cnt_beat),
        .mst_wlast (s_wlast[sel]),
        .last      (cnt_last),
        .wlast_err (wlast_err)
    );

endmodule

// File: tb/tb_axi_wr_router.sv
// -----------------------------------------------------------------------------
// tb_axi_wr_router
//   Self-checking bench for axi_wr_router. The bench plays both the locked
//   master and the slave. Expected AW/W/B transfers are queued when a
//   transaction is set up and popped when the DUT shows the matching
//   handshake; a small phase model predicts every ready/valid bit each cycle.
//   Inputs change 1 time unit after the rising edge, outputs are sampled on
//   the falling edge.
// -----------------------------------------------------------------------------
module tb_axi_wr_router;
    import axi_ic_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    localparam int STRB_W = DATA_W / 8;

    logic                  ACLK;
    logic                  ARESETn;
    logic [3:0]            wgrnt;
    logic [3:0]            s_awvalid, s_awready;
    logic [4*ADDR_W-1:0]   s_awaddr;
    logic [4*ID_W-1:0]     s_awid;
    logic [31:0]           s_awlen;
    logic [3:0]            s_wvalid, s_wready;
    logic [4*DATA_W-1:0]   s_wdata;
    logic [4*STRB_W-1:0]   s_wstrb;
    logic [3:0]            s_wlast;
    logic [3:0]            s_bvalid, s_bready;
    logic [1:0]            s_bresp;
    logic [ID_W-1:0]       s_bid;
    logic                  m_awvalid, m_awready;
    logic [ADDR_W-1:0]     m_awaddr;
    logic [ID_W-1:0]       m_awid;
    logic [7:0]            m_awlen;
    logic                  m_wvalid, m_wready;
    logic [DATA_W-1:0]     m_wdata;
    logic [STRB_W-1:0]     m_wstrb;
    logic                  m_wlast;
    logic                  m_bvalid, m_bready;
    logic [1:0]            m_bresp;
    logic [ID_W-1:0]       m_bid;
    logic                  busy;
    logic [1:0]            sel;
    logic                  wlast_err;

    axi_wr_router #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .wgrnt(wgrnt),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_awid(s_awid), .s_awlen(s_awlen),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_awid(m_awid), .m_awlen(m_awlen),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid),
        .busy(busy), .sel(sel), .wlast_err(wlast_err)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct { logic [ADDR_W-1:0] addr; logic [ID_W-1:0] id; logic [7:0] len; } aw_t;
    typedef struct { logic [DATA_W-1:0] data; logic [STRB_W-1:0] strb; logic last; } w_t;
    typedef struct { logic [3:0] vec; logic [ID_W-1:0] id; logic [1:0] resp; } b_t;

    aw_t exp_aw[$];
    w_t  exp_w[$];
    b_t  exp_b[$];

    int         checks  = 0;
    int         errors  = 0;
    wr_state_e  ph      = IDLE;   // bench model of the router phase
    int         cur_idx = 0;      // master the model expects to be locked
    logic [1:0] exp_sel = 2'd0;

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] m;
        m = 4'b0000;
        m[i] = 1'b1;
        return m;
    endfunction

    // Called on the falling edge: predicts every handshake bit, then pops
    // the scoreboard for whichever transfer the DUT shows this cycle.
    task automatic monitor_cycle();
        logic [3:0]  m;
        logic [14:0] got, exp;
        aw_t a;
        w_t  w;
        b_t  b;
        m   = onehot(cur_idx);
        exp = {(ph == ADDR && m_awready) ? m : 4'b0000,
               (ph == DATA && m_wready)  ? m : 4'b0000,
               (ph == RESP && m_bvalid)  ? m : 4'b0000,
               (ph == ADDR && s_awvalid[cur_idx]),
               (ph == DATA && s_wvalid[cur_idx]),
               (ph == RESP && s_bready[cur_idx])};
        got = {s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_bready};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL handshake_vec t=%0t phase=%0d got=%b want=%b", $time, ph, got, exp);
        end
        checks++;
        if ({busy, sel} !== {ph != IDLE, exp_sel}) begin
            errors++;
            $display("FAIL busy_sel t=%0t got busy=%b sel=%0d want busy=%b sel=%0d",
                     $time, busy, sel, ph != IDLE, exp_sel);
        end
        if (m_awvalid === 1'b1 && m_awready) begin
            checks++;
            if (exp_aw.size() == 0) begin
                errors++;
                $display("FAIL aw_extra t=%0t unexpected AW handshake addr=%h", $time, m_awaddr);
            end else begin
                a = exp_aw.pop_front();
                if ({m_awaddr, m_awid, m_awlen} !== {a.addr, a.id, a.len}) begin
                    errors++;
                    $display("FAIL aw_fields t=%0t got %h/%h/%0d want %h/%h/%0d",
                             $time, m_awaddr, m_awid, m_awlen, a.addr, a.id, a.len);
                end
            end
        end
        if (m_wvalid === 1'b1 && m_wready) begin
            checks++;
            if (exp_w.size() == 0) begin
                errors++;
                $display("FAIL w_extra t=%0t unexpected W handshake data=%h", $time, m_wdata);
            end else begin
                w = exp_w.pop_front();
                if ({m_wdata, m_wstrb, m_wlast} !== {w.data, w.strb, w.last}) begin
                    errors++;
                    $display("FAIL w_beat t=%0t got %h/%h/last=%b want %h/%h/last=%b",
                             $time, m_wdata, m_wstrb, m_wlast, w.data, w.strb, w.last);
                end
            end
        end
        if ((s_bvalid & s_bready) != 4'b0000) begin
            checks++;
            if (exp_b.size() == 0) begin
                errors++;
                $display("FAIL b_extra t=%0t unexpected B handshake bvalid=%b", $time, s_bvalid);
            end else begin
                b = exp_b.pop_front();
                if ({s_bvalid, s_bid, s_bresp} !== {b.vec, b.id, b.resp}) begin
                    errors++;
                    $display("FAIL b_route t=%0t got %b/%h/%b want %b/%h/%b",
                             $time, s_bvalid, s_bid, s_bresp, b.vec, b.id, b.resp);
                end
            end
        end
    endtask

    task automatic drive_beat(input int idx, input w_t w, input logic pin_last);
        s_wdata[idx*DATA_W +: DATA_W] = w.data;
        s_wstrb[idx*STRB_W +: STRB_W] = w.strb;
        s_wlast[idx]                  = pin_last;
    endtask

    // One transaction. bad_beat: beat index on which the master also raises
    // WLAST (-1 none). wr_alt: slave toggles WREADY every cycle. grab: after
    // beat 1 the grant moves to master 0 with AWVALID. abort_at: stop driving
    // once this many beats are done (-1 runs to completion).
    task automatic run_txn(input int idx, input int len, input int bad_beat,
                           input bit wr_alt, input int bdelay, input bit grab,
                           input int abort_at);
        aw_t a;
        w_t  w;
        b_t  b;
        w_t  drv[$];
        int  beat, bcnt, cyc;
        bit  lock, aw_hs, w_hs, wlast_hs, b_hs, done, grabbed;
        cur_idx = idx;
        ph      = IDLE;
        a.addr  = $urandom;
        a.id    = ID_W'($urandom_range(0, 15));
        a.len   = 8'(len);
        exp_aw.push_back(a);
        for (int k = 0; k <= len; k++) begin
            w.data = $urandom;
            w.strb = STRB_W'($urandom_range(1, 15));
            w.last = (k == len);
            exp_w.push_back(w);
            drv.push_back(w);
        end
        b.vec  = onehot(idx);
        b.id   = a.id;
        b.resp = (idx % 2 == 1) ? BRESP_SLVERR : BRESP_OKAY;
        exp_b.push_back(b);

        wgrnt                          = onehot(idx);
        s_awvalid[idx]                 = 1'b1;
        s_awaddr[idx*ADDR_W +: ADDR_W] = a.addr;
        s_awid[idx*ID_W +: ID_W]       = a.id;
        s_awlen[idx*8 +: 8]            = a.len;
        s_wvalid[idx]                  = 1'b1;   // W offered before AW completes
        drive_beat(idx, drv[0], (len == 0) || (bad_beat == 0));
        m_awready = 1'b1;
        m_wready  = 1'b1;
        m_bvalid  = 1'b0;
        beat = 0; bcnt = -1; cyc = 0; done = 1'b0; grabbed = 1'b0;

        while (!done && cyc < 2000) begin
            @(negedge ACLK);
            monitor_cycle();
            lock     = (ph == IDLE) && s_awvalid[idx] && (wgrnt == onehot(idx));
            aw_hs    = (ph == ADDR) && s_awvalid[idx] && m_awready;
            w_hs     = (ph == DATA) && s_wvalid[idx] && m_wready;
            wlast_hs = w_hs && (beat == len);
            b_hs     = (ph == RESP) && m_bvalid && s_bready[idx];
            @(posedge ACLK);
            #1;
            cyc++;
            case (ph)
                IDLE: if (lock)     begin ph = ADDR; exp_sel = 2'(idx); end
                ADDR: if (aw_hs)    ph = DATA;
                DATA: if (wlast_hs) ph = RESP;
                RESP: if (b_hs)     ph = IDLE;
                default: ph = IDLE;
            endcase
            if (aw_hs) s_awvalid[idx] = 1'b0;
            if (w_hs) begin
                beat++;
                if (beat > len) begin
                    s_wvalid[idx] = 1'b0;
                    s_wlast[idx]  = 1'b0;
                end else begin
                    drive_beat(idx, drv[beat], (beat == len) || (beat == bad_beat));
                end
            end
            if (wr_alt) m_wready = ~m_wready;
            if (b_hs) begin
                m_bvalid = 1'b0;
                done     = 1'b1;
            end
            if (wlast_hs) bcnt = bdelay;
            else if (bcnt > 0) bcnt--;
            if (bcnt == 0) begin
                m_bvalid = 1'b1;
                m_bid    = a.id;
                m_bresp  = b.resp;
                bcnt     = -1;
            end
            if (grab && !grabbed && ph == DATA && beat == 1) begin
                wgrnt        = 4'b0001;
                s_awvalid[0] = 1'b1;
                grabbed      = 1'b1;
            end
            if (abort_at >= 0 && ph == DATA && beat == abort_at) done = 1'b1;
        end

        checks++;
        if (!done) begin
            errors++;
            $display("FAIL txn_timeout master=%0d beats_done=%0d of %0d", idx, beat, len + 1);
        end
        wgrnt     = 4'b0000;
        if (abort_at < 0) begin
            s_awvalid = 4'b0000;
            s_wvalid  = 4'b0000;
            checks++;
            if (exp_aw.size() != 0 || exp_w.size() != 0 || exp_b.size() != 0) begin
                errors++;
                $display("FAIL txn_leftover master=%0d aw=%0d w=%0d b=%0d still expected",
                         idx, exp_aw.size(), exp_w.size(), exp_b.size());
            end
            // Lock must be released the cycle after the B handshake
            @(negedge ACLK);
            monitor_cycle();
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic check_err(input string name, input logic want);
        checks++;
        if (wlast_err !== want) begin
            errors++;
            $display("FAIL %s wlast_err got %b want %b", name, wlast_err, want);
        end
    endtask

    task automatic test_reset();
        ARESETn   = 1'b0;
        wgrnt     = 4'b0000;
        s_awvalid = 4'b0000;
        s_awaddr  = '0;
        s_awid    = '0;
        s_awlen   = '0;
        s_wvalid  = 4'b0000;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wlast   = 4'b0000;
        s_bready  = 4'b1111;
        m_awready = 1'b1;
        m_wready  = 1'b1;
        m_bvalid  = 1'b1;
        m_bresp   = BRESP_OKAY;
        m_bid     = '0;
        #12;
        checks++;
        if ({s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_bready, busy, sel, wlast_err} !== 18'b0) begin
            errors++;
            $display("FAIL reset_state got awr=%b wr=%b bv=%b mawv=%b mwv=%b mbr=%b busy=%b sel=%0d err=%b want all 0",
                     s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_bready, busy, sel, wlast_err);
        end
        m_bvalid = 1'b0;
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(posedge ACLK);
        #1;
        ph      = IDLE;
        exp_sel = 2'd0;
    endtask

    task automatic test_basic();
        run_txn(2, 3, -1, 1'b0, 0, 1'b0, -1);
        check_err("basic", 1'b0);
    endtask

    task automatic test_single_beat();
        run_txn(0, 0, -1, 1'b0, 0, 1'b0, -1);
        check_err("single_beat", 1'b0);
    endtask

    task automatic test_grant_change();
        run_txn(1, 3, -1, 1'b0, 0, 1'b1, -1);
        check_err("grant_change", 1'b0);
    endtask

    task automatic test_wlast_err();
        run_txn(1, 3, 1, 1'b0, 0, 1'b0, -1);
        check_err("wlast_err_set", 1'b1);
    endtask

    task automatic test_wait_states();
        run_txn(3, 5, -1, 1'b1, 5, 1'b0, -1);
        check_err("wlast_err_sticky", 1'b1);
    endtask

    task automatic test_awlen_max();
        run_txn(2, 255, -1, 1'b0, 1, 1'b0, -1);
    endtask

    // Non-one-hot grants, and a one-hot grant whose master has no AWVALID,
    // must leave the router in IDLE.
    task automatic test_bad_grant();
        logic [3:0] g_tab [3];
        logic [3:0] v_tab [3];
        g_tab[0] = 4'b0011; v_tab[0] = 4'b0011;
        g_tab[1] = 4'b1111; v_tab[1] = 4'b1111;
        g_tab[2] = 4'b0100; v_tab[2] = 4'b0001;
        ph = IDLE;
        for (int t = 0; t < 3; t++) begin
            wgrnt     = g_tab[t];
            s_awvalid = v_tab[t];
            repeat (3) begin
                @(negedge ACLK);
                monitor_cycle();
                @(posedge ACLK);
                #1;
            end
        end
        wgrnt     = 4'b0000;
        s_awvalid = 4'b0000;
    endtask

    task automatic test_reset_mid();
        run_txn(2, 7, 0, 1'b0, 0, 1'b0, 2);
        check_err("pre_reset_err", 1'b1);
        ARESETn = 1'b0;
        #1;
        checks++;
        if ({s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_bready, busy, sel, wlast_err} !== 18'b0) begin
            errors++;
            $display("FAIL reset_mid got awr=%b wr=%b bv=%b mawv=%b mwv=%b mbr=%b busy=%b sel=%0d err=%b want all 0",
                     s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_bready, busy, sel, wlast_err);
        end
        exp_aw.delete();
        exp_w.delete();
        exp_b.delete();
        s_awvalid = 4'b0000;
        s_wvalid  = 4'b0000;
        s_wlast   = 4'b0000;
        m_bvalid  = 1'b0;
        ph        = IDLE;
        exp_sel   = 2'd0;
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(posedge ACLK);
        #1;
        // Router recovers cleanly after the mid-burst reset
        run_txn(1, 1, -1, 1'b0, 2, 1'b0, -1);
        check_err("post_reset", 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_beat();
        test_grant_change();
        test_wlast_err();
        test_wait_states();
        test_awlen_max();
        test_bad_grant();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_wr_router.md
Name: axi_wr_router

Overview:
- Downstream consumer of the 4-master write arbiter's one-hot grant.
- Locks the granted master for one complete AXI4 write transaction (AW, W burst, B) and routes its channels to the single slave port.
- Counts W beats against AWLEN and generates slave WLAST from that count.
- Releases the lock when the B handshake completes, so the arbiter may rotate.

Parameters:
ADDR_W  32  address width
DATA_W  32  write data width
ID_W    4   transaction ID width

Ports:
ACLK            in   1           clock
ARESETn         in   1           asynchronous active-low reset
wgrnt           in   4           one-hot grant from arbiter, bit i = master i
s_awvalid       in   4           per-master AWVALID
s_awready       out  4           per-master AWREADY
s_awaddr        in   4*ADDR_W    packed, master i at [i*ADDR_W +: ADDR_W]
s_awid          in   4*ID_W      packed AWID
s_awlen         in   4*8         packed AWLEN (beats-1)
s_wvalid        in   4           per-master WVALID
s_wready        out  4           per-master WREADY
s_wdata         in   4*DATA_W    packed WDATA
s_wstrb         in   4*DATA_W/8  packed WSTRB
s_wlast         in   4           per-master WLAST
s_bvalid        out  4           per-master BVALID
s_bready        in   4           per-master BREADY
s_bresp         out  2           BRESP, broadcast; only meaningful with s_bvalid
s_bid           out  ID_W        BID, broadcast
m_awvalid/m_awready/m_awaddr/m_awid/m_awlen   out/in/out/out/out  1/1/ADDR_W/ID_W/8  slave AW
m_wvalid/m_wready/m_wdata/m_wstrb/m_wlast     out/in/out/out/out  1/1/DATA_W/DATA_W/8/1  slave W
m_bvalid/m_bready/m_bresp/m_bid               in/out/in/in  1/1/2/ID_W  slave B
busy            out  1           transaction locked (state != IDLE)
sel             out  2           index of locked master
wlast_err       out  1           sticky: master WLAST disagreed with beat count

Behaviour:
- Reset (async, ARESETn=0):
  - state=IDLE, sel=0, beat counter=0, wlast_err=0.
  - All valid/ready outputs 0; data outputs don't-care. This also applies to reset mid-transaction.
- State machine (registered): IDLE -> ADDR -> DATA -> RESP -> IDLE.
- IDLE:
  - If wgrnt is one-hot and the granted master's s_awvalid=1, latch sel=index and go to ADDR next cycle.
  - Zero or non-one-hot wgrnt: stay in IDLE.
  - No handshakes complete in IDLE. This adds 1 cycle of AW latency.
- ADDR:
  - m_aw* = master[sel] AW fields.
  - s_awready[sel] = m_awready; other bits 0.
  - On m_awvalid&&m_awready: load counter = AWLEN and go to DATA.
- DATA:
  - m_w* = master[sel] W fields.
  - s_wready[sel] = m_wready; m_wlast = (counter==0).
  - Each beat (m_wvalid&&m_wready): counter decrements.
  - Beat with counter==0: go to RESP.
  - Any beat with s_wlast[sel] != (counter==0): set wlast_err=1, held until reset. Routing is unaffected.
- RESP:
  - s_bvalid[sel] = m_bvalid; m_bready = s_bready[sel].
  - s_bresp/s_bid = m_bresp/m_bid.
  - On handshake: go to IDLE; sel holds its value.
- Wait-state handling: m_bvalid, or any master signal arriving early/late, just waits. There is no timeout.
- Grant changes after the lock (IDLE->ADDR) are ignored until IDLE.
- Non-selected masters and channels out of phase always see ready=0 and bvalid=0.
- All channel muxing is combinational from registered sel/state. The only registers are state, sel, counter and wlast_err.
- W data is never accepted before the AW handshake, including any same-cycle W.
- AWLEN=0: a single beat, with m_wlast=1 on the first beat.
- AWLEN=255: 256 beats; the counter is 8 bits and does not wrap before the end.

Decomposition:
- Shared package axi_ic_pkg holds:
  - state encoding localparams (IDLE/ADDR/DATA/RESP)
  - AXI_MASTER_0..3 index constants
  - BRESP codes (OKAY=2'b00, SLVERR=2'b10)
- One natural sub-module: axi_wr_beat_cnt. It provides load/decrement/last with the 8-bit counter and the wlast_err compare.
- Muxes stay inline.

Test Plan:
1. Reset, then wgrnt=4'b0100, s_awvalid[2]=1, AWLEN=3, slave always ready:
   - sel=2 one cycle later, 1 AW handshake, then 4 W beats.
   - m_wlast=1 only on beat 4.
   - B routed only to s_bvalid[2]; busy drops the cycle after the B handshake.
2. AWLEN=0 on master 0 -> single beat with m_wlast=1, then RESP.
3. Mid-DATA, wgrnt switches to 4'b0001 and s_awvalid[0]=1 -> master 0 sees no ready and sel stays put until IDLE.
4. Master asserts s_wlast on beat 2 of 4 -> wlast_err=1 and sticky; the burst still completes with 4 beats.
5. Slave deasserts m_wready on alternate cycles and delays m_bvalid 5 cycles -> beat count and wlast are still correct, and no extra handshakes occur.
6. ARESETn pulsed low in DATA after 2 of 8 beats -> all valid/ready outputs go 0 immediately, state=IDLE, busy=0, wlast_err=0.
